mux_n_stream: RTL
=================

MUX_N_STREAM -- requirements
Module: mux_n_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, data bits per channel (>=1).
REQ-002 The block SHALL have parameter N, default 4, number of input channels (>=2).
REQ-003 The block SHALL have parameter SEL_W, default $clog2(N), select and channel-index width (>=1).
REQ-004 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port sel  input  SEL_W  channel select, used in select mode only.
REQ-007 The block SHALL have port in_valid  input  N  per-channel valid.
REQ-008 The block SHALL have port in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port in_ready  output  N  per-channel ready.
REQ-010 The block SHALL have port out_valid  output  1  output register holds data.
REQ-011 The block SHALL have port out_data  output  WIDTH  registered selected data.
REQ-012 The block SHALL have port out_ch  output  SEL_W  index of the channel out_data came from.
REQ-013 The block SHALL have port out_ready  input  1  downstream accepts out_data.

Function
REQ-014 The block SHALL define load = !out_valid || out_ready as a combinational signal.
REQ-015 The block SHALL compute one combinational grant index g per cycle, with g_ok asserted when g is a legal channel with in_valid[g]=1.
REQ-016 The block SHALL drive in_ready[i] = load && (i == g) && (g < N); all other bits 0.
REQ-017 A channel transfer SHALL occur when in_valid[i] && in_ready[i]; at most one transfer per cycle.
REQ-018 On a transfer, next edge SHALL load out_data <= in_data[g], out_ch <= g, out_valid <= 1 (latency 1 cycle).
REQ-019 When load=1 and there is no transfer, next edge SHALL clear out_valid to 0; out_data and out_ch SHALL hold.
REQ-020 When load=0, out_valid, out_data and out_ch SHALL hold unchanged regardless of inputs.
REQ-021 The block SHALL accept a new beat in the same cycle the previous one drains (out_valid=1, out_ready=1), giving full throughput.
REQ-022 Select mode: g = sel; if sel >= N (non-power-of-two N), in_ready SHALL be all 0 and no transfer SHALL occur.
REQ-023 Select mode: a change of sel SHALL take effect in the same cycle, with no state involved.
REQ-024 The block SHALL have no combinational path from in_data to any output, and none from out_ready to out_*.

Reset
REQ-025 While rst=0, out_valid SHALL be 0, out_data 0, out_ch 0 and the round-robin pointer N-1, all asynchronously.
REQ-026 Reset asserted mid-transfer SHALL discard the held beat; no beat SHALL be emitted until the first edge after rst returns to 1.

Configuration
REQ-027 Macro MUX_N_STREAM_RR_EN SHALL select the grant mode at compile time.
REQ-028 With MUX_N_STREAM_RR_EN undefined, the block SHALL use select mode (REQ-022..023), with no pointer register.
REQ-029 With MUX_N_STREAM_RR_EN defined, sel SHALL be ignored and g SHALL be the first i with in_valid[i]=1, searching circularly from pointer+1 (wrap N-1 -> 0).
REQ-030 In round-robin mode, the pointer SHALL update to g on each transfer only and hold otherwise; with no valid input, in_ready SHALL be all 0.
REQ-031 In round-robin mode, a continuously valid channel SHALL be granted at least once every N transfers.

Verification
REQ-032 The bench SHALL cover select mode: sel=2, in_valid=4'b0100, channel 2 data 4'hA, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=4'hA, out_ch=2.
REQ-033 The bench SHALL cover backpressure: out_valid=1, out_ready=0 for 3 cycles while in_valid=4'b1111 -> in_ready=0 throughout, out_data stable; out_ready=1 -> new beat loads that edge.
REQ-034 The bench SHALL cover round-robin mode (macro defined): in_valid=4'b1111, out_ready=1 held, from reset -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-035 The bench SHALL cover round-robin skip: pointer=1, in_valid=4'b1001 -> grant 3, then grant 0, then grant 3.
REQ-036 The bench SHALL cover reset mid-operation: rst=0 while out_valid=1 -> out_valid=0 immediately, without waiting for clk; after release, channel 0 has first priority in RR mode.
REQ-037 The bench SHALL cover an illegal select: N=3, WIDTH=8, sel=3, in_valid=3'b111 -> in_ready=0 and out_valid falls to 0 after the held beat drains.

Source files
------------

// File: rtl/mux_n_stream.sv
// mux_n_stream: registered N:1 stream mux; select mode by default, round-robin when MUX_N_STREAM_RR_EN is defined.
module mux_n_stream #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_ch,
    input  logic               out_ready
);
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic [SEL_W-1:0] g;
    logic             g_legal, g_ok, load, xfer;
    assign load = !out_valid_q || out_ready;
`ifdef MUX_N_STREAM_RR_EN
    logic [SEL_W-1:0] ptr_q, c;
    logic             unused_sel;
    assign unused_sel = ^sel;
    // descending scan so the closest channel after the pointer wins
    always_comb begin
        g = '0;
        g_legal = 1'b0;
        c = '0;
        for (int k = N; k >= 1; k--) begin
            c = SEL_W'((int'(ptr_q) + k) % N);
            if (in_valid[c]) begin
                g = c;
                g_legal = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= SEL_W'(N - 1);
        else if (xfer) ptr_q <= g;
    end
`else
    assign g = sel;
    assign g_legal = {1'b0, sel} < (SEL_W + 1)'(N);
`endif
    assign g_ok = g_legal && in_valid[g];
    assign xfer = load && g_ok;
    assign in_ready = (load && g_legal) ? (N'(1) << g) : '0;
    always_comb begin
        out_valid_d = load ? xfer : out_valid_q;
        out_data_d = xfer ? WIDTH'(in_data >> (int'(g) * WIDTH)) : out_data_q;
        out_ch_d = xfer ? g : out_ch_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_ch_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            out_ch_q <= out_ch_d;
        end
    end
    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign out_ch = out_ch_q;
endmodule
